dma_apb_master: RTL and testbench
=================================

DMA_APB_MASTER -- requirements
Module: dma_apb_master

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, maximum ACCESS-phase cycles spent waiting for pready before abort (range 2..255).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 cmd_valid  in  1  command request from the sequencer.
REQ-005 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a clock edge.
REQ-006 cmd_write  in  1  1 = APB write, 0 = APB read.
REQ-007 cmd_addr  in  32  target byte address (DMA register map: [5:4] channel, [3:2] register).
REQ-008 cmd_wdata  in  32  write data; ignored for reads.
REQ-009 rsp_valid  out  1  response available.
REQ-010 rsp_ready  in  1  response consumed when rsp_valid && rsp_ready at a clock edge.
REQ-011 rsp_rdata  out  32  read data; 0 for writes and errors.
REQ-012 rsp_err  out  1  transfer failed (pslverr, timeout or misalignment).
REQ-013 rsp_timeout  out  1  failure caused by timeout.
REQ-014 psel, penable, pwrite  out  1 each  APB control.
REQ-015 paddr, pwdata  out  32 each  APB address and write data.
REQ-016 prdata  in  32; pready  in  1; pslverr  in  1  APB completer response.

Function
REQ-017 FSM states are IDLE, SETUP, ACCESS and RESP; all outputs are registered except cmd_ready, which equals (state==IDLE).
REQ-018 IDLE: on command accept with cmd_addr[1:0]==0, latch cmd_write, cmd_addr and cmd_wdata, then go to SETUP.
REQ-019 IDLE: on command accept with cmd_addr[1:0]!=0, go directly to RESP with rsp_err=1, rsp_timeout=0 and rsp_rdata=0; no APB activity occurs.
REQ-020 SETUP (exactly one cycle): psel=1, penable=0; paddr, pwrite and pwdata are driven from the latched values; pwdata=0 for reads; next state is ACCESS.
REQ-021 ACCESS: psel=1, penable=1; paddr, pwrite and pwdata hold their SETUP values unchanged.
REQ-022 ACCESS with pready=1: capture rsp_err=pslverr and rsp_rdata=(read && !pslverr) ? prdata : 0, set rsp_timeout=0, then go to RESP.
REQ-023 ACCESS wait counter: cleared on entry; increments each cycle that pready=0.
REQ-024 ACCESS timeout: if pready=0 in the TIMEOUT_CYCLES-th ACCESS cycle, go to RESP with rsp_err=1, rsp_timeout=1 and rsp_rdata=0.
REQ-025 If pready=1 in the same cycle as the timeout limit, pready wins and the transfer completes normally.
REQ-026 RESP: psel=0, penable=0, rsp_valid=1; rsp_rdata, rsp_err and rsp_timeout are held stable until rsp_ready=1, then the FSM returns to IDLE.
REQ-027 Minimum command-accept-to-rsp_valid latency is 3 clocks (SETUP, ACCESS, RESP); the next command can be accepted 1 cycle after the response handshake.
REQ-028 psel=0 in IDLE and RESP; penable=1 only in ACCESS; pwrite, paddr and pwdata return to 0 in IDLE.
REQ-029 Only one transfer is outstanding at a time; cmd_* inputs are ignored outside IDLE.

Reset
REQ-030 While rst=1 at a clock edge, the FSM enters IDLE and the following are all 0 from the next cycle: psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, rsp_timeout and the wait counter.
REQ-031 Reset asserted mid-SETUP, mid-ACCESS or mid-RESP aborts the transfer; no response is produced for the aborted command.
REQ-032 cmd_ready=1 in the first cycle after reset is released.

Verification
REQ-033 Write: cmd addr=0x14, wdata=0xA5A50000, pready=1 -> SETUP at T+1 (psel=1, penable=0, paddr=0x14), ACCESS at T+2, rsp_valid at T+3 with err=0 and rdata=0.
REQ-034 Read with wait states: addr=0x1C, pready low for 3 ACCESS cycles then high with prdata=0x00000001 -> rsp_rdata=0x1, err=0; paddr stable for all 4 ACCESS cycles.
REQ-035 Slave error: addr=0x40, pslverr=1 with pready=1 -> rsp_err=1, rsp_timeout=0, rsp_rdata=0.
REQ-036 Timeout: pready held 0 -> psel drops after exactly 16 ACCESS cycles; rsp_err=1, rsp_timeout=1; a second run with pready=1 in cycle 16 completes normally.
REQ-037 Misaligned addr=0x06 -> psel stays 0; rsp_valid on the next cycle with err=1; rsp held 5 cycles with rsp_ready=0 and the values stay stable.
REQ-038 rst=1 during ACCESS -> psel=0, penable=0, rsp_valid=0 next cycle; cmd_ready=1 after release; no stale response appears.

Source files
------------

// File: rtl/dma_apb_master_if.sv
// Bundles the sequencer command/response handshake and the APB completer bus
// seen by dma_apb_master.
interface dma_apb_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        input  prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        output prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/dma_apb_master.sv
// Single-outstanding APB requester for the DMA register map: turns one command
// into a SETUP/ACCESS transfer with wait-state timeout and returns one response.
module dma_apb_master #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic         clk,
    input logic         rst,
    dma_apb_master_if.master bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // wait_cnt holds the number of ACCESS cycles already spent with pready low
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_r, state_s;
    logic        psel_r, psel_s;
    logic        penable_r, penable_s;
    logic        pwrite_r, pwrite_s;
    logic [31:0] paddr_r, paddr_s;
    logic [31:0] pwdata_r, pwdata_s;
    logic        rsp_valid_r, rsp_valid_s;
    logic [31:0] rsp_rdata_r, rsp_rdata_s;
    logic        rsp_err_r, rsp_err_s;
    logic        rsp_timeout_r, rsp_timeout_s;
    logic [7:0]  wait_cnt_r, wait_cnt_s;

    // State register and registered copies of every bus/response output
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            psel_r        <= 1'b0;
            penable_r     <= 1'b0;
            pwrite_r      <= 1'b0;
            paddr_r       <= 32'h0;
            pwdata_r      <= 32'h0;
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= 32'h0;
            rsp_err_r     <= 1'b0;
            rsp_timeout_r <= 1'b0;
            wait_cnt_r    <= 8'd0;
        end else begin
            state_r       <= state_s;
            psel_r        <= psel_s;
            penable_r     <= penable_s;
            pwrite_r      <= pwrite_s;
            paddr_r       <= paddr_s;
            pwdata_r      <= pwdata_s;
            rsp_valid_r   <= rsp_valid_s;
            rsp_rdata_r   <= rsp_rdata_s;
            rsp_err_r     <= rsp_err_s;
            rsp_timeout_r <= rsp_timeout_s;
            wait_cnt_r    <= wait_cnt_s;
        end
    end

    // Next state plus the values the outputs take in that next state
    always_comb begin
        state_s       = state_r;
        psel_s        = 1'b0;
        penable_s     = 1'b0;
        pwrite_s      = pwrite_r;
        paddr_s       = paddr_r;
        pwdata_s      = pwdata_r;
        rsp_valid_s   = 1'b0;
        rsp_rdata_s   = rsp_rdata_r;
        rsp_err_s     = rsp_err_r;
        rsp_timeout_s = rsp_timeout_r;
        wait_cnt_s    = 8'd0;
        case (state_r)
            IDLE: begin
                pwrite_s = 1'b0;
                paddr_s  = 32'h0;
                pwdata_s = 32'h0;
                if (bus.cmd_valid) begin
                    if (bus.cmd_addr[1:0] == 2'b00) begin
                        state_s  = SETUP;
                        psel_s   = 1'b1;
                        pwrite_s = bus.cmd_write;
                        paddr_s  = bus.cmd_addr;
                        pwdata_s = bus.cmd_write ? bus.cmd_wdata : 32'h0;
                    end else begin
                        state_s       = RESP;
                        rsp_valid_s   = 1'b1;
                        rsp_rdata_s   = 32'h0;
                        rsp_err_s     = 1'b1;
                        rsp_timeout_s = 1'b0;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            SETUP: begin
                state_s   = ACCESS;
                psel_s    = 1'b1;
                penable_s = 1'b1;
            end
            ACCESS: begin
                if (bus.pready) begin
                    state_s       = RESP;
                    rsp_valid_s   = 1'b1;
                    rsp_err_s     = bus.pslverr;
                    rsp_timeout_s = 1'b0;
                    rsp_rdata_s   = (!pwrite_r && !bus.pslverr) ? bus.prdata : 32'h0;
                    pwrite_s      = 1'b0;
                    paddr_s       = 32'h0;
                    pwdata_s      = 32'h0;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    state_s       = RESP;
                    rsp_valid_s   = 1'b1;
                    rsp_err_s     = 1'b1;
                    rsp_timeout_s = 1'b1;
                    rsp_rdata_s   = 32'h0;
                    pwrite_s      = 1'b0;
                    paddr_s       = 32'h0;
                    pwdata_s      = 32'h0;
                end else begin
                    psel_s     = 1'b1;
                    penable_s  = 1'b1;
                    wait_cnt_s = wait_cnt_r + 8'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_s       = IDLE;
                    rsp_rdata_s   = 32'h0;
                    rsp_err_s     = 1'b0;
                    rsp_timeout_s = 1'b0;
                end else begin
                    rsp_valid_s = 1'b1;
                end
            end
            default: begin
                state_s       = IDLE;
                pwrite_s      = 1'b0;
                paddr_s       = 32'h0;
                pwdata_s      = 32'h0;
                rsp_rdata_s   = 32'h0;
                rsp_err_s     = 1'b0;
                rsp_timeout_s = 1'b0;
            end
        endcase
    end

    assign bus.cmd_ready   = (state_r == IDLE);
    assign bus.psel        = psel_r;
    assign bus.penable     = penable_r;
    assign bus.pwrite      = pwrite_r;
    assign bus.paddr       = paddr_r;
    assign bus.pwdata      = pwdata_r;
    assign bus.rsp_valid   = rsp_valid_r;
    assign bus.rsp_rdata   = rsp_rdata_r;
    assign bus.rsp_err     = rsp_err_r;
    assign bus.rsp_timeout = rsp_timeout_r;
endmodule

// File: tb/tb_dma_apb_master.sv
// Directed bench for dma_apb_master: each task drives one scenario and checks
// the bus and response cycle by cycle against hand-computed values.
module tb_dma_apb_master;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    dma_apb_master_if bus ();

    dma_apb_master #(.TIMEOUT_CYCLES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h0;
        bus.cmd_wdata = 32'h0;
        bus.rsp_ready = 1'b0;
        bus.prdata    = 32'h0;
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;
    endtask

    task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if ({bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl got %b want 000000", {bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout});
        end
        vectors++;
        if ({bus.paddr, bus.pwdata, bus.rsp_rdata} !== 96'h0) begin
            miscompares++;
            $display("FAIL reset_data got %h %h %h want 0", bus.paddr, bus.pwdata, bus.rsp_rdata);
        end
        rst = 1'b0;
        tick();
        vectors++;
        if (bus.cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_cmd_ready got %b want 1", bus.cmd_ready);
        end
    endtask

    task automatic test_write();
        bus.pready = 1'b1;
        send_cmd(1'b1, 32'h14, 32'hA5A5_0000);
        vectors++;
        if ({bus.psel, bus.penable, bus.pwrite, bus.cmd_ready} !== 4'b1010 || bus.paddr !== 32'h14 || bus.pwdata !== 32'hA5A5_0000) begin
            miscompares++;
            $display("FAIL wr_setup got sel/en/wr/rdy=%b addr=%h wdata=%h", {bus.psel, bus.penable, bus.pwrite, bus.cmd_ready}, bus.paddr, bus.pwdata);
        end
        tick();
        vectors++;
        if ({bus.psel, bus.penable} !== 2'b11 || bus.paddr !== 32'h14 || bus.pwdata !== 32'hA5A5_0000) begin
            miscompares++;
            $display("FAIL wr_access got sel/en=%b addr=%h wdata=%h", {bus.psel, bus.penable}, bus.paddr, bus.pwdata);
        end
        tick();
        vectors++;
        if ({bus.psel, bus.penable, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout} !== 5'b00100 || bus.rsp_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL wr_resp got sel/en/v/err/to=%b rdata=%h want 00100 0", {bus.psel, bus.penable, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}, bus.rsp_rdata);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        vectors++;
        if ({bus.rsp_valid, bus.cmd_ready, bus.pwrite} !== 3'b010 || bus.paddr !== 32'h0 || bus.pwdata !== 32'h0) begin
            miscompares++;
            $display("FAIL wr_idle got v/rdy/wr=%b addr=%h wdata=%h", {bus.rsp_valid, bus.cmd_ready, bus.pwrite}, bus.paddr, bus.pwdata);
        end
    endtask

    task automatic test_read_wait();
        bus.pready = 1'b0;
        bus.prdata = 32'h0000_0001;
        send_cmd(1'b0, 32'h1C, 32'hFFFF_FFFF);
        vectors++;
        if (bus.pwdata !== 32'h0 || bus.pwrite !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_setup_wdata got pwdata=%h pwrite=%b want 0 0", bus.pwdata, bus.pwrite);
        end
        // A foreign command mid-transfer must not disturb the latched address
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 32'h0000_0030;
        tick();
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if ({bus.psel, bus.penable} !== 2'b11 || bus.paddr !== 32'h1C || bus.rsp_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL rd_access_%0d got sel/en=%b addr=%h v=%b", i, {bus.psel, bus.penable}, bus.paddr, bus.rsp_valid);
            end
            bus.pready = (i == 3);
            tick();
        end
        bus.cmd_valid = 1'b0;
        bus.pready    = 1'b0;
        vectors++;
        if ({bus.psel, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout} !== 4'b0100 || bus.rsp_rdata !== 32'h1) begin
            miscompares++;
            $display("FAIL rd_resp got sel/v/err/to=%b rdata=%h want 0100 00000001", {bus.psel, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}, bus.rsp_rdata);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_slave_err();
        bus.pready  = 1'b1;
        bus.pslverr = 1'b1;
        bus.prdata  = 32'hDEAD_BEEF;
        send_cmd(1'b0, 32'h40, 32'h0);
        tick();
        tick();
        vectors++;
        if ({bus.rsp_valid, bus.rsp_err, bus.rsp_timeout} !== 3'b110 || bus.rsp_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL slverr_resp got v/err/to=%b rdata=%h want 110 0", {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}, bus.rsp_rdata);
        end
        bus.pslverr   = 1'b0;
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_timeout();
        int sel_cycles;
        bus.pready = 1'b0;
        send_cmd(1'b0, 32'h24, 32'h0);
        tick();
        sel_cycles = 0;
        for (int k = 1; k <= 20; k++) begin
            if (bus.penable === 1'b1) sel_cycles++;
            tick();
        end
        vectors++;
        if (sel_cycles !== 16) begin
            miscompares++;
            $display("FAIL timeout_len got %0d access cycles want 16", sel_cycles);
        end
        vectors++;
        if ({bus.psel, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout} !== 4'b0111 || bus.rsp_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL timeout_resp got sel/v/err/to=%b rdata=%h want 0111 0", {bus.psel, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}, bus.rsp_rdata);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;

        bus.prdata = 32'h1234_5678;
        send_cmd(1'b0, 32'h28, 32'h0);
        tick();
        for (int k = 1; k <= 16; k++) begin
            bus.pready = (k == 16);
            tick();
        end
        bus.pready = 1'b0;
        vectors++;
        if ({bus.rsp_valid, bus.rsp_err, bus.rsp_timeout} !== 3'b100 || bus.rsp_rdata !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL timeout_edge got v/err/to=%b rdata=%h want 100 12345678", {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}, bus.rsp_rdata);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_misaligned();
        bus.pready = 1'b1;
        send_cmd(1'b1, 32'h06, 32'hCAFE_F00D);
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if ({bus.psel, bus.penable, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.cmd_ready} !== 6'b001100 || bus.rsp_rdata !== 32'h0 || bus.paddr !== 32'h0) begin
                miscompares++;
                $display("FAIL misalign_hold_%0d got sel/en/v/err/to/rdy=%b rdata=%h addr=%h", i, {bus.psel, bus.penable, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.cmd_ready}, bus.rsp_rdata, bus.paddr);
            end
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        vectors++;
        if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL misalign_release got v/rdy=%b want 01", {bus.rsp_valid, bus.cmd_ready});
        end
    endtask

    task automatic test_reset_mid_access();
        int stale;
        bus.pready = 1'b0;
        send_cmd(1'b1, 32'h34, 32'h0000_00AA);
        tick();
        rst = 1'b1;
        tick();
        vectors++;
        if ({bus.psel, bus.penable, bus.rsp_valid} !== 3'b000) begin
            miscompares++;
            $display("FAIL rst_access got sel/en/v=%b want 000", {bus.psel, bus.penable, bus.rsp_valid});
        end
        rst = 1'b0;
        bus.pready = 1'b1;
        tick();
        vectors++;
        if (bus.cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_release_ready got %b want 1", bus.cmd_ready);
        end
        stale = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.rsp_valid !== 1'b0 || bus.psel !== 1'b0) stale++;
            tick();
        end
        vectors++;
        if (stale !== 0) begin
            miscompares++;
            $display("FAIL rst_stale_rsp got %0d active cycles want 0", stale);
        end
    endtask

    task automatic test_back_to_back();
        bus.pready = 1'b1;
        send_cmd(1'b1, 32'h0C, 32'h0000_1111);
        tick();
        tick();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        bus.prdata = 32'h0000_2222;
        send_cmd(1'b0, 32'h08, 32'h0);
        vectors++;
        if ({bus.psel, bus.pwrite} !== 2'b10 || bus.paddr !== 32'h08) begin
            miscompares++;
            $display("FAIL b2b_setup got sel/wr=%b addr=%h want 10 00000008", {bus.psel, bus.pwrite}, bus.paddr);
        end
        tick();
        tick();
        vectors++;
        if ({bus.rsp_valid, bus.rsp_err} !== 2'b10 || bus.rsp_rdata !== 32'h0000_2222) begin
            miscompares++;
            $display("FAIL b2b_resp got v/err=%b rdata=%h want 10 00002222", {bus.rsp_valid, bus.rsp_err}, bus.rsp_rdata);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        idle_inputs();
        test_reset();
        test_write();
        test_read_wait();
        test_slave_err();
        test_timeout();
        test_misaligned();
        test_reset_mid_access();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
